// File: rtl/eaglesong_bit_matrix_mult_if.sv
// eaglesong_bit_matrix_mult_if
//   Handshake and data bundle between a requester (master) and the
//   bit-matrix multiplier (slave).
//   start                 : begin one multiplication (master -> slave)
//   state_in[511:0]       : 16 x 32-bit input words, word w at [32w+31:32w]
//   bit_index_to_request  : matrix bit index asked for (slave -> master)
//   requested_bit         : matrix bit for the current index (master -> slave)
//   busy / done           : run status, one-cycle done pulse (slave -> master)
//   state_out[511:0]      : result, same packing as state_in
//   abort                 : cancel a run; only when EAGLESONG_BMM_ABORT_EN
interface eaglesong_bit_matrix_mult_if;
  logic         start;
  logic [511:0] state_in;
  logic [7:0]   bit_index_to_request;
  logic         requested_bit;
  logic         busy;
  logic         done;
  logic [511:0] state_out;
`ifdef EAGLESONG_BMM_ABORT_EN
  logic         abort;

  modport master (output start, state_in, requested_bit, abort,
                  input  bit_index_to_request, busy, done, state_out);
  modport slave  (input  start, state_in, requested_bit, abort,
                  output bit_index_to_request, busy, done, state_out);
`else
  modport master (output start, state_in, requested_bit,
                  input  bit_index_to_request, busy, done, state_out);
  modport slave  (input  start, state_in, requested_bit,
                  output bit_index_to_request, busy, done, state_out);
`endif
endinterface

// File: rtl/eaglesong_bit_matrix_mult.sv
// eaglesong_bit_matrix_mult
//   Serial GF(2) 16x16 word-matrix multiply used by the Eaglesong permutation:
//   out[j] = XOR_k (M[16k+j] ? in[k] : 0). The 256-bit matrix lives outside
//   and is read one bit per cycle through bit_index_to_request/requested_bit.
//   One result every 258 cycles: 1 IDLE (start) + 256 RUN + 1 DONE.
// Ports
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : eaglesong_bit_matrix_mult_if.slave (start, state_in,
//           bit_index_to_request, requested_bit, busy, done, state_out[, abort])
// Build option
//   EAGLESONG_BMM_ABORT_EN : adds bus.abort, which cancels a run in progress
//   without a done pulse and leaves state_out untouched.
//
// state | meaning
// IDLE  | waiting for start; bit index held at 0
// RUN   | one matrix bit per cycle, counter 0..255 = {k, j}
// DONE  | result copied to state_out, done pulse high
module eaglesong_bit_matrix_mult (
  input logic clk,
  input logic reset,
  eaglesong_bit_matrix_mult_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [511:0] lat_q, lat_d;
  logic [511:0] acc_q, acc_d;
  logic [511:0] out_q, out_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  // Word offsets: counter high nibble selects the source word k,
  // low nibble the destination word j.
  logic [8:0]   src_base;
  logic [8:0]   dst_base;

  assign src_base = {cnt_q[7:4], 5'd0};
  assign dst_base = {cnt_q[3:0], 5'd0};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    acc_d   = acc_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          lat_d   = bus.state_in;
          acc_d   = '0;
          cnt_d   = 8'd0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
`ifdef EAGLESONG_BMM_ABORT_EN
        if (bus.abort) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          busy_d  = 1'b0;
        end else begin
`else
        begin
`endif
          if (bus.requested_bit) begin
            acc_d[dst_base +: 32] = acc_q[dst_base +: 32] ^ lat_q[src_base +: 32];
          end
          // Wraps to 0 on the last bit, so the counter is already clear in DONE.
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'hFF) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            // Take acc_d so the contribution of bit 255 is included.
            out_d   = acc_d;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      lat_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.bit_index_to_request = busy_q ? cnt_q : 8'd0;
  assign bus.busy                 = busy_q;
  assign bus.done                 = done_q;
  assign bus.state_out            = out_q;

endmodule
